// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, overrun and framing-error reporting
module uart_rx #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_sync1;
    logic          r_sync2;
    logic          w_rx_s;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_next;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic          w_good;
    logic          w_bad;

    assign w_rx_s = r_sync2;
    assign busy   = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_sync1 <= RxD;
            r_sync2 <= r_sync1;
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt + CW'(1);
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (!w_rx_s) w_next = S_START;
            end
            S_START: begin
                // A line that is high again at mid start bit was only a glitch
                if (r_cnt == HALF_LAST) begin
                    w_cnt_next = '0;
                    w_idx_next = '0;
                    w_next     = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == FULL_LAST) begin
                    w_cnt_next   = '0;
                    w_shift_next = {w_rx_s, r_shift[7:1]};
                    w_idx_next   = r_idx + 3'd1;
                    if (r_idx == 3'd7) w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == FULL_LAST) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_next = S_IDLE;
                        w_good = 1'b1;
                    end else begin
                        w_next = S_WAIT_HIGH;
                        w_bad  = 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                w_cnt_next = '0;
                if (w_rx_s) w_next = S_IDLE;
            end
            default: begin
                w_cnt_next = '0;
                w_next     = S_IDLE;
            end
        endcase
    end

    // A frame completing alongside an ack replaces the byte without flagging overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= w_bad;
            if (w_good) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ack) rx_overrun <= 1'b1;
            end else if (rx_ack && rx_valid) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule
